// File: rtl/cnn_pkg.sv
// Shared constants, types and helpers for the cellular-neural-network iteration controller.
// Holds the default data format, the FSM encoding, neighbour offsets and the output clamp.
package cnn_pkg;

  localparam int WIDTH = 9;
  localparam int FRAC  = 4;
  localparam int ONE   = 1 << FRAC;

  function automatic int acc_width(input int w);
    return 2 * w + 5;
  endfunction

  localparam int ACC_W = acc_width(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_e;

  typedef struct packed {
    logic signed [1:0] dr;
    logic signed [1:0] dc;
  } nbr_t;

  // Template position k (row-major 3x3, centre at k=4) to neighbour offset.
  function automatic nbr_t nbr_off(input logic [3:0] k);
    nbr_t o;
    int   q;
    int   m;
    q    = int'(k) / 3;
    m    = int'(k) % 3;
    o.dr = 2'(q - 1);
    o.dc = 2'(m - 1);
    return o;
  endfunction

  // Piecewise-linear CNN output: clamp to [-lim, +lim].
  function automatic logic signed [31:0] sat_pm(input logic signed [31:0] x,
                                                input logic signed [31:0] lim);
    if (x > lim) return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

endpackage

// File: rtl/cnn_cell_mac.sv
// Cell-state datapath: 9-step A*Y + B*U accumulation with zero boundary substitution,
// followed by combinational scale, bias and output clamp.
module cnn_cell_mac
  import cnn_pkg::acc_width, cnn_pkg::sat_pm;
#(
  parameter int WIDTH = 9,
  parameter int FRAC  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld_p1,
  input  logic                    clr_p1,
  input  logic                    zero_p1,
  input  logic signed [WIDTH-1:0] a_coef,
  input  logic signed [WIDTH-1:0] b_coef,
  input  logic signed [WIDTH-1:0] y_data,
  input  logic signed [WIDTH-1:0] u_data,
  input  logic signed [WIDTH-1:0] bias,
  output logic signed [WIDTH-1:0] wr_data
);

  localparam int ACC_W = acc_width(WIDTH);
  localparam int ONE   = 1 << FRAC;

  logic signed [WIDTH-1:0]   y_eff;
  logic signed [WIDTH-1:0]   u_eff;
  logic signed [2*WIDTH-1:0] prod_a;
  logic signed [2*WIDTH-1:0] prod_b;
  logic signed [ACC_W-1:0]   term;
  logic signed [ACC_W-1:0]   acc_p2;
  logic signed [ACC_W-1:0]   x;

  // ---- stage p1: read data arrives, multiply and sum ----
  always_comb begin
    y_eff  = zero_p1 ? '0 : y_data;
    u_eff  = zero_p1 ? '0 : u_data;
    prod_a = a_coef * y_eff;
    prod_b = b_coef * u_eff;
    term   = ACC_W'(prod_a) + ACC_W'(prod_b);
  end

  // ---- stage p2: accumulator ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= clr_p1 ? term : acc_p2 + term;
    end
  end

  always_comb begin
    x       = (acc_p2 >>> FRAC) + ACC_W'(bias);
    wr_data = WIDTH'(sat_pm(32'(x), 32'(ONE)));
  end

endmodule

// File: rtl/cnn_iter_ctrl.sv
// Iteration controller: walks the grid cell by cell, issues 3x3 neighbourhood reads,
// drives the shared MAC and writes new Y into the opposite ping-pong bank.
module cnn_iter_ctrl
  import cnn_pkg::state_e, cnn_pkg::nbr_t, cnn_pkg::nbr_off,
         cnn_pkg::IDLE, cnn_pkg::ISSUE, cnn_pkg::DRAIN, cnn_pkg::WRITE;
#(
  parameter int WIDTH = cnn_pkg::WIDTH,
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int FRAC  = cnn_pkg::FRAC,
  parameter int AW    = $clog2(ROWS * COLS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [7:0]              iters,
  input  logic [9*WIDTH-1:0]      a_tmpl,
  input  logic [9*WIDTH-1:0]      b_tmpl,
  input  logic signed [WIDTH-1:0] i_bias,
  output logic                    rd_en,
  output logic [AW-1:0]           rd_addr,
  output logic                    rd_bank,
  input  logic signed [WIDTH-1:0] y_rd_data,
  input  logic signed [WIDTH-1:0] u_rd_data,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic                    wr_bank,
  output logic signed [WIDTH-1:0] wr_data,
  output logic                    busy,
  output logic                    done,
  output logic                    bank_sel,
  output logic [7:0]              iter_cnt
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  state_e                  state;
  state_e                  state_nx;
  logic [3:0]              k;
  logic [RW-1:0]           row;
  logic [CW-1:0]           col;
  logic [7:0]              iters_r;
  logic signed [WIDTH-1:0] a_r [9];
  logic signed [WIDTH-1:0] b_r [9];
  logic signed [WIDTH-1:0] bias_r;
  logic                    vld_p1;
  logic                    zero_p1;
  logic [3:0]              k_p1;
  logic                    last_col;
  logic                    last_row;
  logic                    last_iter;
  nbr_t                    off;
  int                      nr;
  int                      nc;
  logic                    in_grid;

  always_comb begin
    off       = nbr_off(k);
    nr        = int'(row) + int'(off.dr);
    nc        = int'(col) + int'(off.dc);
    in_grid   = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
    last_col  = (col == CW'(COLS - 1));
    last_row  = (row == RW'(ROWS - 1));
    last_iter = ((iter_cnt + 8'd1) == iters_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (iters == 8'd0) ? IDLE : ISSUE;
      ISSUE:   if (k == 4'd8) state_nx = DRAIN;
      DRAIN:   state_nx = WRITE;
      WRITE:   state_nx = (last_col && last_row && last_iter) ? IDLE : ISSUE;
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // Out-of-grid neighbours never strobe the memory; address is parked at 0 when idle.
  always_comb begin
    rd_en   = (state == ISSUE) && in_grid;
    rd_addr = rd_en ? AW'(nr * COLS + nc) : '0;
    rd_bank = bank_sel;
    wr_en   = (state == WRITE);
    wr_addr = AW'(int'(row) * COLS + int'(col));
    wr_bank = wr_en & ~bank_sel;
    busy    = (state != IDLE);
  end

  // ---- stage p0: issue, cell/iteration counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k        <= '0;
      row      <= '0;
      col      <= '0;
      bank_sel <= 1'b0;
      iter_cnt <= '0;
      done     <= 1'b0;
      vld_p1   <= 1'b0;
      zero_p1  <= 1'b0;
      k_p1     <= '0;
    end else begin
      done   <= 1'b0;
      vld_p1 <= 1'b0;
      if (!abort) begin
        case (state)
          IDLE: if (start) begin
            bank_sel <= 1'b0;
            iter_cnt <= '0;
            row      <= '0;
            col      <= '0;
            k        <= '0;
            if (iters == 8'd0) done <= 1'b1;
          end
          ISSUE: begin
            vld_p1  <= 1'b1;
            zero_p1 <= ~in_grid;
            k_p1    <= k;
            k       <= (k == 4'd8) ? 4'd0 : k + 4'd1;
          end
          WRITE: begin
            if (last_col) begin
              col <= '0;
              if (last_row) begin
                row      <= '0;
                bank_sel <= ~bank_sel;
                iter_cnt <= iter_cnt + 8'd1;
                if (last_iter) done <= 1'b1;
              end else begin
                row <= row + RW'(1);
              end
            end else begin
              col <= col + CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        a_r[i] <= '0;
        b_r[i] <= '0;
      end
      bias_r  <= '0;
      iters_r <= '0;
    end else if (state == IDLE && start && !abort) begin
      for (int i = 0; i < 9; i++) begin
        a_r[i] <= a_tmpl[i*WIDTH +: WIDTH];
        b_r[i] <= b_tmpl[i*WIDTH +: WIDTH];
      end
      bias_r  <= i_bias;
      iters_r <= iters;
    end
  end

  // ---- stage p1/p2: MAC and output conversion ----
  cnn_cell_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .vld_p1  (vld_p1),
    .clr_p1  (k_p1 == 4'd0),
    .zero_p1 (zero_p1),
    .a_coef  (a_r[k_p1]),
    .b_coef  (b_r[k_p1]),
    .y_data  (y_rd_data),
    .u_data  (u_rd_data),
    .bias    (bias_r),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_cnn_iter_ctrl.sv
// Scoreboard bench for cnn_iter_ctrl on a 4x4 grid with a behavioural ping-pong Y / U memory.
module tb_cnn_iter_ctrl;

  localparam int W   = 9;
  localparam int R   = 4;
  localparam int C   = 4;
  localparam int AWD = 4;
  localparam int N   = R * C;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [7:0]          iters = 8'd0;
  logic [9*W-1:0]      a_tmpl = '0;
  logic [9*W-1:0]      b_tmpl = '0;
  logic signed [W-1:0] i_bias = '0;
  logic                rd_en;
  logic [AWD-1:0]      rd_addr;
  logic                rd_bank;
  logic signed [W-1:0] y_rd_data;
  logic signed [W-1:0] u_rd_data;
  logic                wr_en;
  logic [AWD-1:0]      wr_addr;
  logic                wr_bank;
  logic signed [W-1:0] wr_data;
  logic                busy;
  logic                done;
  logic                bank_sel;
  logic [7:0]          iter_cnt;

  always #5 clk = ~clk;

  cnn_iter_ctrl #(.WIDTH(W), .ROWS(R), .COLS(C), .FRAC(4), .AW(AWD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .iters(iters),
    .a_tmpl(a_tmpl), .b_tmpl(b_tmpl), .i_bias(i_bias),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .y_rd_data(y_rd_data), .u_rd_data(u_rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
    .busy(busy), .done(done), .bank_sel(bank_sel), .iter_cnt(iter_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural memory: Y ping-pong banks and U image, 1-cycle read latency.
  logic signed [W-1:0] ymem [2][N];
  logic signed [W-1:0] umem [N];
  logic load_req = 1'b0;
  int   ld_y0 = 0;
  int   ld_y1 = 0;
  int   ld_u  = 0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) begin
        ymem[0][i] <= W'(ld_y0);
        ymem[1][i] <= W'(ld_y1);
        umem[i]    <= W'(ld_u);
      end
    end else if (wr_en) begin
      ymem[wr_bank][wr_addr] <= wr_data;
    end
    if (rd_en) begin
      y_rd_data <= ymem[rd_bank][rd_addr];
      u_rd_data <= umem[rd_addr];
    end else begin
      y_rd_data <= 9'sd77;
      u_rd_data <= -9'sd53;
    end
  end

  typedef struct {
    int addr;
    int bank;
    int data;
  } exp_t;
  exp_t sbq[$];

  int rd0 = 0;
  int rd1 = 0;
  int wr_cnt = 0;

  // Monitor: counts strobes and checks each write against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        if (rd_bank) rd1++;
        else         rd0++;
      end
      if (wr_en) begin
        exp_t e;
        wr_cnt++;
        chk("write_expected", int'(sbq.size() > 0), 1);
        chk("wr_bank_inv", int'(wr_bank), int'(!rd_bank));
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("wr_addr", int'(wr_addr), e.addr);
          chk("wr_bank", int'(wr_bank), e.bank);
          chk("wr_data", int'(wr_data), e.data);
        end
      end
    end
  end

  int bnd [N] = '{4, 6, 6, 4, 6, 9, 9, 6, 6, 9, 9, 6, 4, 6, 6, 4};

  function automatic logic [9*W-1:0] tm(input int ctr, input int oth);
    logic [9*W-1:0] t;
    t = '0;
    for (int k = 0; k < 9; k++) t[k*W +: W] = W'((k == 4) ? ctr : oth);
    return t;
  endfunction

  function automatic logic [31:0] outs_all();
    return {rd_en, rd_addr, rd_bank, wr_en, wr_addr, wr_bank, wr_data,
            busy, done, bank_sel, iter_cnt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int y0, input int y1, input int u);
    ld_y0 = y0; ld_y1 = y1; ld_u = u;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic push_cells(input int bank, input int data, input int ncells);
    for (int i = 0; i < ncells; i++) sbq.push_back('{addr: i, bank: bank, data: data});
  endtask

  task automatic pulse_start(input int it);
    start = 1'b1;
    iters = 8'(it);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      tick();
      cyc++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  task automatic run(input int it, output int lat);
    pulse_start(it);
    wait_done(2000, lat);
  endtask

  int lat;
  int b_rd0, b_rd1, b_wr;
  int dcount;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk("reset_outputs", int'(outs_all()), 0);
    rst_n = 1'b1;
    tick();

    // Identity template
    load(8, 0, 0);
    a_tmpl = tm(16, 0); b_tmpl = '0; i_bias = '0;
    push_cells(1, 8, N);
    b_rd0 = rd0; b_rd1 = rd1; b_wr = wr_cnt;
    run(1, lat);
    chk("identity_latency", lat, 176);
    chk("identity_busy_low", int'(busy), 0);
    chk("identity_bank_sel", int'(bank_sel), 1);
    chk("identity_iter_cnt", int'(iter_cnt), 1);
    chk("identity_reads", rd0 - b_rd0, 100);
    chk("identity_writes", wr_cnt - b_wr, 16);
    tick();
    chk("done_one_cycle", int'(done), 0);

    // Bias saturation, positive then negative
    load(0, 0, 16);
    a_tmpl = '0; b_tmpl = tm(16, 0); i_bias = 9'sd8;
    push_cells(1, 16, N);
    run(1, lat);
    chk("bias_pos_latency", lat, 176);
    load(0, 0, 0);
    i_bias = -9'sd40;
    push_cells(1, -16, N);
    run(1, lat);
    chk("bias_neg_bank_sel", int'(bank_sel), 1);

    // Zero boundary
    load(1, 0, 0);
    a_tmpl = tm(16, 16); b_tmpl = '0; i_bias = '0;
    for (int i = 0; i < N; i++) sbq.push_back('{addr: i, bank: 1, data: bnd[i]});
    b_rd0 = rd0; b_rd1 = rd1;
    run(1, lat);
    chk("boundary_reads_b0", rd0 - b_rd0, 100);
    chk("boundary_reads_b1", rd1 - b_rd1, 0);

    // Ping-pong over three iterations, with an ignored start mid-run
    load(8, 3, 0);
    a_tmpl = tm(16, 0); b_tmpl = '0; i_bias = 9'sd1;
    push_cells(1, 9, N);
    push_cells(0, 10, N);
    push_cells(1, 11, N);
    b_rd0 = rd0; b_rd1 = rd1;
    pulse_start(3);
    repeat (30) tick();
    pulse_start(1);
    iters = 8'd3;
    wait_done(2000, lat);
    chk("pingpong_latency", lat + 31, 528);
    chk("pingpong_bank_sel", int'(bank_sel), 1);
    chk("pingpong_iter_cnt", int'(iter_cnt), 3);
    chk("pingpong_reads_b0", rd0 - b_rd0, 200);
    chk("pingpong_reads_b1", rd1 - b_rd1, 100);

    // Zero iterations
    b_rd0 = rd0; b_rd1 = rd1; b_wr = wr_cnt;
    run(0, lat);
    chk("zero_iter_latency", lat, 0);
    chk("zero_iter_busy", int'(busy), 0);
    chk("zero_iter_bank_sel", int'(bank_sel), 0);
    chk("zero_iter_iter_cnt", int'(iter_cnt), 0);
    tick();
    chk("zero_iter_done_pulse", int'(done), 0);
    repeat (3) tick();
    chk("zero_iter_strobes", (rd0 - b_rd0) + (rd1 - b_rd1) + (wr_cnt - b_wr), 0);

    // Abort in the 5th cycle of cell 6, then a clean restart
    load(8, 0, 0);
    a_tmpl = tm(16, 0); b_tmpl = '0; i_bias = '0;
    push_cells(1, 8, 6);
    b_wr = wr_cnt;
    pulse_start(1);
    repeat (70) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_iter_cnt", int'(iter_cnt), 0);
    chk("abort_bank_sel", int'(bank_sel), 0);
    chk("abort_strobes", int'({rd_en, wr_en}), 0);
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      dcount += int'(done);
    end
    chk("abort_no_done", dcount, 0);
    chk("abort_writes", wr_cnt - b_wr, 6);
    load(8, 0, 0);
    push_cells(1, 8, N);
    run(1, lat);
    chk("restart_latency", lat, 176);
    chk("restart_bank_sel", int'(bank_sel), 1);
    chk("restart_iter_cnt", int'(iter_cnt), 1);

    // Asynchronous reset during a write
    load(8, 0, 0);
    pulse_start(1);
    dcount = 0;
    while (!wr_en && dcount < 40) begin
      tick();
      dcount++;
    end
    chk("reset_reach_write", int'(wr_en), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_async_outputs", int'(outs_all()), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_release_outputs", int'(outs_all()), 0);
    load(8, 0, 0);
    push_cells(1, 8, N);
    run(1, lat);
    chk("post_reset_latency", lat, 176);
    chk("post_reset_bank_sel", int'(bank_sel), 1);

    repeat (3) tick();
    chk("scoreboard_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_iter_ctrl.md
Name: cnn_iter_ctrl

Overview:
- Sequences one shared cell-state datapath across a ROWS x COLS grid of a cellular neural network for a programmable number of iterations.
- Per cell: fetches the 3x3 Y and U neighbourhoods, accumulates sum(A*Y) + sum(B*U), scales, adds bias I, applies the CNN output nonlinearity and writes the new Y.
- Y storage is ping-pong (two banks); U storage is a single read-only image.

Parameters:
- WIDTH, 9, signed data/template width.
- ROWS, 8, grid rows.
- COLS, 8, grid columns.
- FRAC, 4, fractional bits; fixed-point 1.0 = ONE = 1<<FRAC.
- AW, $clog2(ROWS*COLS), cell address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- start  in  1  one-cycle pulse; begins a run
- abort  in  1  stops a run and returns to IDLE
- iters  in  8  number of iterations
- a_tmpl  in  9*WIDTH  feedback template; k=0 at [WIDTH-1:0], row-major, k=4 is the centre
- b_tmpl  in  9*WIDTH  control template, same layout
- i_bias  in  WIDTH  bias I
- rd_en  out  1  read strobe
- rd_addr  out  AW  cell index r*COLS+c
- rd_bank  out  1  Y bank being read
- y_rd_data  in  WIDTH  Y data, 1 cycle after rd_en
- u_rd_data  in  WIDTH  U data, 1 cycle after rd_en
- wr_en  out  1  Y write strobe
- wr_addr  out  AW  Y write address
- wr_bank  out  1  equals ~rd_bank
- wr_data  out  WIDTH  new Y
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- bank_sel  out  1  current read bank; holds the result bank after done
- iter_cnt  out  8  completed iterations

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All outputs and registers reset to 0; the FSM resets to IDLE.
- States: IDLE, ISSUE, DRAIN, WRITE.
- IDLE:
  - On start: latch a_tmpl, b_tmpl, i_bias and iters; clear bank_sel, iter_cnt, row, col and k.
  - Enter ISSUE; busy rises the cycle after start.
  - If iters=0: skip to done instead (one cycle after start, no reads or writes).
- ISSUE (9 cycles, k=0..8): neighbour (r+dr, c+dc) with dr=k/3-1, dc=k%3-1.
  - In-grid neighbour: rd_en=1, rd_addr is its index.
  - Out-of-grid neighbour: rd_en=0, and the MAC stage substitutes 0 for both Y and U (fixed zero boundary).
- MAC stage: one cycle behind issue.
  - acc += A[k]*Y + B[k]*U, with A and B taken from the registered templates.
  - acc is signed 2*WIDTH+5 bits, cleared at k=0; no overflow is possible.
- DRAIN (1 cycle): last MAC completes.
- WRITE (1 cycle):
  - x = (acc >>> FRAC) + sign-extended I.
  - wr_data = clamp(x, -ONE, +ONE), which is the piecewise-linear CNN output.
  - wr_en=1, wr_addr=r*COLS+c, wr_bank=~bank_sel.
- Cell time is exactly 11 cycles. Cells advance row-major: col wraps at COLS-1 and increments row.
- After the last cell of an iteration: toggle bank_sel, increment iter_cnt.
  - If iter_cnt reaches iters: go to IDLE, pulse done, drop busy in the same cycle.
  - Otherwise restart at cell (0,0).
- Iteration time is ROWS*COLS*11 cycles.
- start while busy: ignored.
- abort: takes priority over all else. Next cycle: IDLE, busy=0, rd_en=0, wr_en=0, no done. bank_sel and iter_cnt hold. A write in the same cycle as abort still completes.
- Asynchronous reset mid-run: immediate return to IDLE with all outputs at 0.
- rd_bank always equals bank_sel.

Decomposition:
- Package cnn_pkg:
  - WIDTH, FRAC, ONE.
  - Accumulator width constant.
  - FSM state enum.
  - Neighbour offset function k -> (dr, dc).
  - Saturate function.
- One sub-module, cnn_cell_mac: registered 9-step multiply-accumulate with zero-substitute, final scale/bias/clamp. Combinational apart from the acc register.
- The controller keeps the FSM, counters and address generation.

Test Plan (ROWS=COLS=4, FRAC=4):
- Identity: A centre 16, others 0; B=0; I=0; Y=8 everywhere; iters=1 -> every wr_data=8. 16 writes to bank 1. done 176 cycles after busy rises. bank_sel=1.
- Bias saturation: A=0; B centre 16; U=16; I=8 -> x=24, wr_data=16. I=-40 -> x=-40, wr_data=-16.
- Boundary: all A=16; B=0; I=0; Y=1 -> corner cells write 4, edge cells 6, interior cells 9. Out-of-grid k never raises rd_en (exactly 100 rd_en cycles per iteration).
- Ping-pong: iters=3 -> reads alternate bank 0,1,0; writes 1,0,1. Final bank_sel=1, iter_cnt=3. iters=0 -> done one cycle after start, no rd_en or wr_en.
- Abort and restart: abort in the 5th cycle of cell 6 of iteration 0 -> next cycle busy=0, no done, iter_cnt=0. A start pulse during the run is ignored. A subsequent start completes normally.
- Reset: rst_n low mid-WRITE -> all outputs 0 asynchronously; after release, start runs a clean full iteration.
